apb_slave_mem: RTL
==================

# apb_slave_mem

Wait-state-capable APB slave: a word-addressed register bank sitting directly downstream of the APB bus interface and serving the transfers driven by the master driver. Decodes PADDR against a base window, inserts a fixed number of wait states via PREADY, commits writes from the shared PDATA bus and drives PDATA on reads. It is the DUT-side consumer the APB UVC agents exercise.

## Interface

**Parameters**
- DATA_WIDTH, 32: width of PDATA and each storage word.
- DEPTH, 16: number of storage words, a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be aligned to DEPTH*4.
- WAIT_STATES, 2: wait cycles inserted in every access phase, range 0..15.

**Ports**
- PCLK, input, 1: clock. All state updates happen on the rising edge.
- PRESET, input, 1: reset, asynchronous and active-high.
- PADDR, input, 32: byte address, sampled in the setup phase.
- PWRITE, input, 1: 1 means write, 0 means read. Sampled in the setup phase.
- PSEL, input, 1: slave select.
- PENABLE, input, 1: access-phase marker.
- PDATA, inout, DATA_WIDTH: shared data bus.
  - The master drives it for writes.
  - This block drives it for reads only; otherwise it is high-Z.
- PREADY, output, 1: transfer completes on the edge where PSEL, PENABLE and PREADY are all 1.

## Operation

**State machine states:** IDLE, ACCESS.

**Captured registers**
- addr_q: address captured in setup.
- wr_q: write flag captured in setup.
- hit_q: set when the address is in range.
- cnt: wait counter, 4 bits.

**Address decode**
- The address is in range when BASE_ADDR <= PADDR < BASE_ADDR + DEPTH*4.
- Word index = (PADDR - BASE_ADDR) >> 2. PADDR[1:0] is ignored.

**IDLE**
- On an edge with PSEL=1 and PENABLE=0 (setup phase):
  - capture PADDR, PWRITE and hit;
  - set cnt = WAIT_STATES;
  - go to ACCESS.
- All other inputs are ignored.

**ACCESS**
- PREADY = PSEL & PENABLE & (cnt==0). This is combinational from registered state and inputs.
- Edge with PSEL & PENABLE & cnt != 0: cnt decrements by 1.
- Edge with PSEL & PENABLE & PREADY:
  - If wr_q & hit_q: mem[index] <= PDATA.
  - Go to IDLE.
- Edge with PSEL=1 and PENABLE=0: treated as a fresh setup. Recapture address and write flag, reload cnt, stay in ACCESS. The aborted transfer has no side effects.
- Edge with PSEL=0: abort and go to IDLE. No write occurs.
- A change of PADDR or PWRITE during ACCESS is ignored; the captured values are used.

**Read drive**
- PDATA is driven when state==ACCESS, wr_q=0, PSEL=1 and PENABLE=1.
- Value driven: mem[index] if hit_q, else 0.
- PDATA is high-Z at all other times, including while PRESET is asserted.

**Out-of-range accesses**
- Writes are discarded.
- Reads return 0.
- Wait states still apply.

**Reset (PRESET=1, at any time including mid-transfer)**
- state=IDLE, cnt=0, addr_q=0, wr_q=0, hit_q=0.
- All mem words are 0.
- PREADY=0 and PDATA is high-Z, immediately and without waiting for a clock edge.
- An in-flight write is dropped.

## Timing

- **Transfer length:** 2 + WAIT_STATES cycles (setup, then 1 + WAIT_STATES access cycles).
- **WAIT_STATES=0:** PREADY is 1 in the first access cycle.
- **Back-to-back transfers:** a setup phase in the cycle right after completion is accepted. There is no dead cycle.
- **Write visibility:** a written value is readable starting with the next transfer.
- **Read data stability:** read data is valid and stable for the whole access phase, so it is stable whenever PREADY=1.
- **PREADY outside the access phase:** PREADY is never 1 outside ACCESS with PSEL & PENABLE.

## Test plan

1. **Reset values:** assert PRESET mid-cycle → PREADY=0 and PDATA high-Z immediately. After release, read addr 0x0 → 0x0000_0000.
2. **Write then read, WAIT_STATES=2:** write 0xDEAD_BEEF to 0x0000_0008, then read 0x0000_0008 →
   - PREADY rises in the 3rd access cycle;
   - the read returns 0xDEAD_BEEF;
   - each transfer takes 4 cycles.
3. **Zero wait states, back-to-back:** with WAIT_STATES=0, write 0x1 to 0x0 and 0x2 to 0x4 on consecutive transfers, then read both → 0x1 and 0x2; every transfer is 2 cycles with no idle cycle between them.
4. **Out-of-range:** write 0x5555_5555 to 0x0000_0040 (DEPTH=16) → no word changes; a read of 0x40 returns 0; PREADY timing is unchanged. Also read 0x0000_003C → returns its own stored value.
5. **Abort:** a write access phase where PSEL drops before PREADY → the target word is unchanged and the FSM is IDLE. A following read completes normally.
6. **Reset mid-write:** assert PRESET during the wait states of a write of 0xA5A5_A5A5 to 0xC → after release, a read of 0xC returns 0 and PREADY stays 0 until the next access phase.

Source files
------------

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB register bank with fixed wait states and a shared bidirectional data bus
// Ports:
//   PCLK     - clock, all state changes on the rising edge
//   PRESET   - asynchronous active-high reset, clears state and storage
//   PADDR    - byte address, captured in the setup phase
//   PWRITE   - 1 = write, 0 = read, captured in the setup phase
//   PSEL     - slave select
//   PENABLE  - access-phase marker
//   PDATA    - shared data bus, driven here only during read access phases
//   PREADY   - completes the transfer when high together with PSEL and PENABLE
module apb_slave_mem #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [31:0]           PADDR,
    input  logic                  PWRITE,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    inout  wire  [DATA_WIDTH-1:0] PDATA,
    output logic                  PREADY
);
    localparam int AW = $clog2(DEPTH);
    // 33 bits so the window end cannot wrap when compared against the offset
    localparam logic [32:0] SPAN = 33'(DEPTH * 4);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AW-1:0]         r_idx;
    logic                  r_wr;
    logic                  r_hit;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [31:0]           w_off;
    logic                  w_hit;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_write;
    logic                  w_rd_en;

    assign w_off    = PADDR - BASE_ADDR;
    assign w_hit    = (PADDR >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
    assign w_setup  = PSEL & ~PENABLE;
    // PRESET gates the outputs directly so they drop without waiting for the flops
    assign w_access = PSEL & PENABLE & (r_state == ACCESS) & ~PRESET;
    assign PREADY   = w_access & (r_cnt == 4'd0);
    assign w_write  = PREADY & r_wr & r_hit;
    assign w_rd_en  = w_access & ~r_wr;
    assign PDATA    = w_rd_en ? (r_hit ? r_mem[r_idx] : '0) : {DATA_WIDTH{1'bz}};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A setup phase always (re)starts a transfer; otherwise stay only while the
    // access phase is still waiting with PSEL held.
    always_comb begin
        w_next = w_setup ? ACCESS : (r_state == ACCESS && PSEL && !PREADY) ? ACCESS : IDLE;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_idx <= '0;
            r_wr  <= 1'b0;
            r_hit <= 1'b0;
            r_cnt <= 4'd0;
        end else if (w_setup) begin
            r_idx <= w_off[AW+1:2];
            r_wr  <= PWRITE;
            r_hit <= w_hit;
            r_cnt <= 4'(WAIT_STATES);
        end else if (w_access && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_write) begin
            r_mem[r_idx] <= PDATA;
        end
    end
endmodule
